// File: rtl/srl_test_pkg.sv
// Shared types and constants for the SRL init/pattern checker: FSM states,
// the data LFSR definition and the supported lane count.
package srl_test_pkg;

  typedef enum logic [1:0] {
    IDLE,
    INIT_CHK,
    PAT_CHK,
    DONE
  } state_t;

  localparam logic [7:0] LFSR_SEED = 8'h01;
  // Taps for x^8+x^6+x^5+x^4+1 on a left-shifting Fibonacci register
  localparam logic [7:0] LFSR_TAPS = 8'hB8;
  localparam int         MAX_LANES = 8;

  function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
    return {cur[6:0], ^(cur & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/srl_test_lfsr8.sv
// 8-bit Fibonacci LFSR that only advances when enabled; reset reloads the seed.
module srl_test_lfsr8
  import srl_test_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output logic [7:0] state
);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= LFSR_SEED;
    end else if (en) begin
      state <= lfsr_next(state);
    end
  end

endmodule

// File: rtl/srl_init_checker.sv
// Drives data/CE into a bank of SRL shift registers and checks each tail
// output against a shadow copy, latching a sticky per-lane error flag.
module srl_init_checker
  import srl_test_pkg::*;
#(
  parameter int                     LANES  = 8,
  parameter int                     DEPTH  = 32,
  parameter logic [LANES*DEPTH-1:0] INIT   = {LANES*DEPTH{1'b0}},
  parameter int                     PASSES = 4
) (
  input  logic             clk,
  input  logic             rst,
  output logic [LANES-1:0] srl_d,
  output logic             srl_ce,
  input  logic [LANES-1:0] srl_q,
  output logic [LANES-1:0] error,
  output logic             done
);

  localparam int             TOTAL   = PASSES * DEPTH;
  localparam int             NW      = $clog2(TOTAL) + 1;
  localparam logic [NW-1:0]  DEPTH_N = NW'(DEPTH);
  localparam logic [NW-1:0]  TOTAL_N = NW'(TOTAL);

  state_t          state;
  logic [1:0]      cyc;
  logic [1:0]      cyc_n;
  logic [NW-1:0]   nshift;
  logic [NW-1:0]   nshift_n;
  logic            init_end;
  logic            last_shift;
  logic [7:0]      lfsr;
  logic [LANES-1:0] tails;

  srl_test_lfsr8 u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .en    (srl_ce),
    .state (lfsr)
  );

  assign srl_d = lfsr[LANES-1:0];

  assign cyc_n      = cyc + 2'd1;
  assign nshift_n   = nshift + NW'(srl_ce);
  assign init_end   = srl_ce && (nshift_n == DEPTH_N);
  assign last_shift = srl_ce && (nshift_n == TOTAL_N);

  // srl_ce is computed from the next cyc value so the registered output
  // drops for one cycle in every four while a check phase is running.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      srl_ce <= 1'b0;
      done   <= 1'b0;
      cyc    <= 2'd0;
      nshift <= '0;
    end else begin
      cyc    <= cyc_n;
      nshift <= nshift_n;
      unique case (state)
        IDLE: begin
          state  <= INIT_CHK;
          srl_ce <= (cyc_n != 2'd3);
        end
        INIT_CHK: begin
          if (last_shift) begin
            state  <= DONE;
            srl_ce <= 1'b0;
            done   <= 1'b1;
          end else begin
            if (init_end) begin
              state <= PAT_CHK;
            end
            srl_ce <= (cyc_n != 2'd3);
          end
        end
        PAT_CHK: begin
          if (last_shift) begin
            state  <= DONE;
            srl_ce <= 1'b0;
            done   <= 1'b1;
          end else begin
            srl_ce <= (cyc_n != 2'd3);
          end
        end
        DONE: begin
          srl_ce <= 1'b0;
          done   <= 1'b1;
        end
        default: begin
          state  <= IDLE;
          srl_ce <= 1'b0;
        end
      endcase
    end
  end

  // The shadow deliberately has no reset so it stays aligned with the SRL
  // contents across a mid-run restart.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [DEPTH-1:0] shadow = INIT[i*DEPTH +: DEPTH];

    always_ff @(posedge clk) begin
      if (srl_ce) begin
        shadow <= {shadow[DEPTH-2:0], srl_d[i]};
      end
    end

    assign tails[i] = shadow[DEPTH-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      error <= '0;
    end else if (srl_ce) begin
      error <= error | (srl_q ^ tails);
    end
  end

endmodule
